id_stage: RTL

Parametrised decode stage with integrated ID/EX pipeline register, operand forwarding and load-use hazard stall. Sits between the IF stage and EX, and reads the register file combinationally. It generalises the fixed 32-bit decode/ID-EX pair: data width is parametrised, and it adds a valid/ready handshake, EX/WB bypass, bubble insertion and a flush path. The load address is pre-computed so EX can issue the RIB read one cycle early.

---
 rtl/id_stage_pkg.sv | 49 ++++
 rtl/id_stage_imm_gen.sv | 36 +++
 rtl/id_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage_pkg
//  Brief    : Shared core defines for the decode stage. Holds the RV32I base
//             opcodes, the canonical NOP word and immediate-format encodings.
//  Revision : 1.0  initial release
// ============================================================================
package id_stage_pkg;

  // RV32I base opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ADDI x0,x0,0 -- the word shown on bubbles and out of reset
  localparam logic [31:0] NOP_INS_DEFAULT = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // Map an opcode to the immediate layout it carries
  function automatic imm_type_e imm_type_of(input logic [6:0] opc);
    imm_type_e t;
    t = IMM_NONE;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: t = IMM_I;
      OPC_STORE:                      t = IMM_S;
      OPC_BRANCH:                     t = IMM_B;
      OPC_LUI, OPC_AUIPC:             t = IMM_U;
      OPC_JAL:                        t = IMM_J;
      default:                        t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : id_imm_gen
//  Brief    : Combinational immediate extractor. Builds the 32-bit immediate
//             for the instruction format, then sign-extends it to XLEN.
//  Revision : 1.0  initial release
// ============================================================================
module id_imm_gen
  import id_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ins_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  // Assemble the 32-bit form of the immediate and widen it with its sign bit
  always_comb begin
    imm32 = 32'd0;
    case (imm_type_of(ins_i[6:0]))
      IMM_I:   imm32 = {{20{ins_i[31]}}, ins_i[31:20]};
      IMM_S:   imm32 = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
      IMM_B:   imm32 = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25],
                        ins_i[11:8], 1'b0};
      IMM_U:   imm32 = {ins_i[31:12], 12'd0};
      IMM_J:   imm32 = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20],
                        ins_i[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
    imm_o = XLEN'($signed(imm32));
  end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage
//  Brief    : Decode stage with ID/EX pipeline register, EX/WB operand
//             bypass, load-use bubble insertion and flush. Pre-computes the
//             load address so EX can issue the RIB read one cycle early.
//  Revision : 1.0  initial release
// ============================================================================
module id_stage
  import id_stage_pkg::*;
#(
  parameter int          XLEN    = 32,
  parameter int          REG_AW  = 5,
  parameter logic [31:0] NOP_INS = NOP_INS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       ins_i,
  input  logic [XLEN-1:0]   ins_addr_i,
  output logic [REG_AW-1:0] reg1_rd_addr_o,
  output logic [REG_AW-1:0] reg2_rd_addr_o,
  input  logic [XLEN-1:0]   reg1_rd_data_i,
  input  logic [XLEN-1:0]   reg2_rd_data_i,
  input  logic              ex_wr_en_i,
  input  logic [REG_AW-1:0] ex_wr_addr_i,
  input  logic [XLEN-1:0]   ex_wr_data_i,
  input  logic              ex_is_load_i,
  input  logic              wb_wr_en_i,
  input  logic [REG_AW-1:0] wb_wr_addr_i,
  input  logic [XLEN-1:0]   wb_wr_data_i,
  output logic              out_valid_o,
  output logic [31:0]       ins_o,
  output logic [XLEN-1:0]   ins_addr_o,
  output logic [6:0]        opcode_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [XLEN-1:0]   reg1_rd_data_o,
  output logic [XLEN-1:0]   reg2_rd_data_o,
  output logic [REG_AW-1:0] reg_wr_addr_o,
  output logic              reg_wr_en_o,
  output logic              mem_rd_rib_req_o,
  output logic [XLEN-1:0]   mem_rd_addr_o,
  output logic              illegal_o
);

  typedef struct packed {
    logic              valid;
    logic [31:0]       ins;
    logic [XLEN-1:0]   ins_addr;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic              mem_req;
    logic [XLEN-1:0]   mem_addr;
    logic              illegal;
  } idex_t;

  // Empty slot: everything zero except the instruction word
  function automatic idex_t bubble();
    idex_t b;
    b     = '0;
    b.ins = NOP_INS;
    return b;
  endfunction

  // Operand bypass: x0 is hard zero; a non-load EX result beats WB, WB beats RF
  function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] a,
                                          input logic [XLEN-1:0]   rf);
    logic [XLEN-1:0] r;
    if (a == '0)                                           r = '0;
    else if (ex_wr_en_i && !ex_is_load_i && ex_wr_addr_i == a) r = ex_wr_data_i;
    else if (wb_wr_en_i && wb_wr_addr_i == a)              r = wb_wr_data_i;
    else                                                   r = rf;
    return r;
  endfunction

  logic [6:0]        opcode;
  logic              rs1_used;
  logic              rs2_used;
  logic              writes_rd;
  logic              is_load;
  logic              legal;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   rs1_fwd;
  logic [XLEN-1:0]   rs2_fwd;
  logic              load_use;
  idex_t             decoded;
  idex_t             idex_d;
  idex_t             idex_q;

  id_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .ins_i (ins_i),
    .imm_o (imm)
  );

  // Classify the opcode: which sources it reads, whether it writes rd
  always_comb begin
    opcode    = ins_i[6:0];
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    legal     = 1'b1;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
      OPC_JALR:   begin rs1_used = 1'b1; writes_rd = 1'b1; end
      OPC_BRANCH: begin rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_LOAD:   begin rs1_used = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end
      OPC_STORE:  begin rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_OP_IMM: begin rs1_used = 1'b1; writes_rd = 1'b1; end
      OPC_OP:     begin rs1_used = 1'b1; rs2_used = 1'b1; writes_rd = 1'b1; end
      default:    legal = 1'b0;
    endcase
  end

  // Unused source fields read x0 so they never hit the bypass or hazard logic
  always_comb begin
    rs1_addr = rs1_used ? REG_AW'(ins_i[19:15]) : '0;
    rs2_addr = rs2_used ? REG_AW'(ins_i[24:20]) : '0;
    rs1_fwd  = fwd(rs1_addr, reg1_rd_data_i);
    rs2_fwd  = fwd(rs2_addr, reg2_rd_data_i);
  end

  assign reg1_rd_addr_o = rs1_addr;
  assign reg2_rd_addr_o = rs2_addr;

  // A load in EX has no data yet: hold the dependent instruction for one cycle
  always_comb begin
    load_use = in_valid_i && ex_is_load_i && ex_wr_en_i && (ex_wr_addr_i != '0) &&
               ((rs1_used && ex_wr_addr_i == rs1_addr) ||
                (rs2_used && ex_wr_addr_i == rs2_addr));
    in_ready_o = !stall_i && !load_use;
  end

  // Build the ID/EX payload for the instruction currently in ID
  always_comb begin
    decoded          = '0;
    decoded.valid    = 1'b1;
    decoded.ins      = ins_i;
    decoded.ins_addr = ins_addr_i;
    decoded.opcode   = opcode;
    decoded.funct3   = ins_i[14:12];
    decoded.funct7   = ins_i[31:25];
    decoded.imm      = imm;
    decoded.rs1_data = rs1_fwd;
    decoded.rs2_data = rs2_fwd;
    decoded.rd       = REG_AW'(ins_i[11:7]);
    decoded.wr_en    = writes_rd && (ins_i[11:7] != 5'd0);
    decoded.mem_req  = is_load;
    decoded.mem_addr = is_load ? (rs1_fwd + imm) : '0;
    decoded.illegal  = !legal;
  end

  // ID/EX update priority: flush, stall, load-use, capture, idle bubble
  always_comb begin
    idex_d = idex_q;
    if (flush_i)         idex_d = bubble();
    else if (stall_i)    idex_d = idex_q;
    else if (load_use)   idex_d = bubble();
    else if (in_valid_i) idex_d = decoded;
    else                 idex_d = bubble();
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= bubble();
    else        idex_q <= idex_d;
  end

  assign out_valid_o      = idex_q.valid;
  assign ins_o            = idex_q.ins;
  assign ins_addr_o       = idex_q.ins_addr;
  assign opcode_o         = idex_q.opcode;
  assign funct3_o         = idex_q.funct3;
  assign funct7_o         = idex_q.funct7;
  assign imm_o            = idex_q.imm;
  assign reg1_rd_data_o   = idex_q.rs1_data;
  assign reg2_rd_data_o   = idex_q.rs2_data;
  assign reg_wr_addr_o    = idex_q.rd;
  assign reg_wr_en_o      = idex_q.wr_en;
  assign mem_rd_rib_req_o = idex_q.mem_req;
  assign mem_rd_addr_o    = idex_q.mem_addr;
  assign illegal_o        = idex_q.illegal;

endmodule
`default_nettype wire
